// File: rtl/vp_frame_ctrl.sv
// Frame-synchronous output controller: aligns raw timing to the converter latency,
// switches output format only on frame starts, and measures active frame geometry.
module vp_frame_ctrl #(
  parameter int LATENCY = 3,
  parameter int HW      = 12,
  parameter int VW      = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          de,
  input  logic          hsync,
  input  logic          vsync,
  input  logic [23:0]   pixel_in,
  input  logic [23:0]   ycc_in,
  input  logic [1:0]    mode_req,
  output logic          de_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [23:0]   pixel_out,
  output logic [1:0]    mode_active,
  output logic [HW-1:0] h_size,
  output logic [VW-1:0] v_size,
  output logic          geom_stable
);

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic [LATENCY-1:0] de_sr, hs_sr, vs_sr;
  logic [23:0]        pix_sr [LATENCY];
  logic               de_d, hs_d, vs_d, vs_d_q, fs;
  logic [23:0]        pixel_d, pix_sel;
  logic [1:0]         state, state_nx, mode_nx;

  logic               de_q, vs_q, de_rise, vs_rise;
  logic [HW-1:0]      hcnt, hlast;
  logic [VW-1:0]      vcnt;
  logic               frame_seen, pub_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
      for (int i = 0; i < LATENCY; i++) pix_sr[i] <= '0;
    end else begin
      de_sr[0]  <= de;
      hs_sr[0]  <= hsync;
      vs_sr[0]  <= vsync;
      pix_sr[0] <= pixel_in;
      for (int i = 1; i < LATENCY; i++) begin
        de_sr[i]  <= de_sr[i-1];
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
        pix_sr[i] <= pix_sr[i-1];
      end
    end
  end

  assign de_d    = de_sr[LATENCY-1];
  assign hs_d    = hs_sr[LATENCY-1];
  assign vs_d    = vs_sr[LATENCY-1];
  assign pixel_d = pix_sr[LATENCY-1];
  assign fs      = vs_d & ~vs_d_q;

  // A request is only armed (PEND) while it differs from the active mode; the
  // value present in the frame-start cycle is the one that gets applied.
  always_comb begin
    state_nx = state;
    mode_nx  = mode_active;
    case (state)
      S_SYNC: if (fs) begin
        state_nx = S_RUN;
        mode_nx  = mode_req;
      end
      S_RUN: if (mode_req != mode_active) state_nx = S_PEND;
      S_PEND: begin
        if (fs) begin
          state_nx = S_RUN;
          mode_nx  = mode_req;
        end else if (mode_req == mode_active) begin
          state_nx = S_RUN;
        end
      end
      default: state_nx = S_SYNC;
    endcase
  end

  // Mux on the next-state mode so the frame-start pixel already uses the new format.
  always_comb begin
    pix_sel = '0;
    if (de_d && state_nx != S_SYNC) begin
      case (mode_nx)
        2'd0:    pix_sel = pixel_d;
        2'd1:    pix_sel = ycc_in;
        2'd2:    pix_sel = {3{ycc_in[23:16]}};
        default: pix_sel = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_SYNC;
      mode_active <= '0;
      vs_d_q      <= 1'b0;
      de_out      <= 1'b0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      pixel_out   <= '0;
    end else begin
      state       <= state_nx;
      mode_active <= mode_nx;
      vs_d_q      <= vs_d;
      de_out      <= de_d;
      hsync_out   <= hs_d;
      vsync_out   <= vs_d;
      pixel_out   <= pix_sel;
    end
  end

  assign de_rise = de & ~de_q;
  assign vs_rise = vsync & ~vs_q;

  // Geometry runs on the undelayed input; the first vsync edge only arms publication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_q        <= 1'b0;
      vs_q        <= 1'b0;
      hcnt        <= '0;
      hlast       <= '0;
      vcnt        <= '0;
      frame_seen  <= 1'b0;
      pub_valid   <= 1'b0;
      h_size      <= '0;
      v_size      <= '0;
      geom_stable <= 1'b0;
    end else begin
      de_q <= de;
      vs_q <= vsync;
      if (de) begin
        if (hcnt != '1) hcnt <= hcnt + 1'b1;
      end else if (de_q) begin
        hlast <= hcnt;
        hcnt  <= '0;
      end
      if (vs_rise) begin
        vcnt       <= de_rise ? {{(VW-1){1'b0}}, 1'b1} : '0;
        frame_seen <= 1'b1;
        if (frame_seen) begin
          h_size      <= hlast;
          v_size      <= vcnt;
          geom_stable <= pub_valid && (hlast == h_size) && (vcnt == v_size);
          pub_valid   <= 1'b1;
        end
      end else if (de_rise && vcnt != '1) begin
        vcnt <= vcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vp_frame_ctrl.sv
// Self-checking bench for vp_frame_ctrl: a cycle-history reference model checked every
// cycle, plus directed literal expectations for the scenarios of interest.
module tb_vp_frame_ctrl;

  localparam int LAT  = 3;
  localparam int HW   = 12;
  localparam int VW   = 11;
  localparam int MAXC = 16384;

  logic          clk = 1'b0;
  logic          rst_n, de, hsync, vsync;
  logic [23:0]   pixel_in, ycc_in;
  logic [1:0]    mode_req;
  logic          de_out, hsync_out, vsync_out, geom_stable;
  logic [23:0]   pixel_out;
  logic [1:0]    mode_active;
  logic [HW-1:0] h_size;
  logic [VW-1:0] v_size;

  always #5 clk = ~clk;

  vp_frame_ctrl #(.LATENCY(LAT), .HW(HW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .de(de), .hsync(hsync), .vsync(vsync),
    .pixel_in(pixel_in), .ycc_in(ycc_in), .mode_req(mode_req),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .pixel_out(pixel_out), .mode_active(mode_active),
    .h_size(h_size), .v_size(v_size), .geom_stable(geom_stable)
  );

  int checks = 0;
  int passes = 0;

  // Per-cycle record of everything the bench drove; reset cycles stored as idle.
  bit          rstA [MAXC];
  bit          deA  [MAXC];
  bit          hsA  [MAXC];
  bit          vsA  [MAXC];
  logic [23:0] pixA [MAXC];
  logic [23:0] yccA [MAXC];
  logic [1:0]  modeA[MAXC];
  int          cyc = 0;
  bit          started = 0;

  bit          stubConst = 0;
  bit          greyProbe = 0;
  bit          blackProbe = 0;
  logic [1:0]  reqMode = 2'd0;
  int          fno = 0;

  function automatic logic [23:0] conv(input logic [23:0] p);
    return {p[7:0] ^ 8'h3C, p[23:16] + 8'h11, p[15:8] ^ 8'hA5};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic applyStimulus(input bit r, input bit d, input bit h, input bit v,
                               input logic [23:0] p);
    @(negedge clk);
    if (cyc >= MAXC) begin
      $display("[TB] FAIL history_overflow: got %0d, expected below %0d", cyc, MAXC);
      $fatal(1, "[TB] history overflow");
    end
    rst_n    = r;
    de       = d;
    hsync    = h;
    vsync    = v;
    pixel_in = p;
    mode_req = reqMode;
    ycc_in   = stubConst ? 24'hC82B3A : ((cyc >= LAT) ? conv(pixA[cyc-LAT]) : 24'h0);
    rstA[cyc]  = !r;
    deA[cyc]   = r & d;
    hsA[cyc]   = r & h;
    vsA[cyc]   = r & v;
    pixA[cyc]  = r ? p : 24'h0;
    yccA[cyc]  = ycc_in;
    modeA[cyc] = reqMode;
    started = 1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 24'h0);
  endtask

  task automatic applyVsync();
    applyStimulus(1, 0, 0, 1, 24'h0);
    applyStimulus(1, 0, 0, 1, 24'h0);
    applyStimulus(1, 0, 0, 0, 24'h0);
    applyStimulus(1, 0, 0, 0, 24'h0);
  endtask

  task automatic applyLine(input int w, input int l, input int chgLine, input int chgPix,
                           input logic [1:0] chgVal, input int chg2Line, input logic [1:0] chg2Val);
    logic [23:0] p;
    for (int i = 0; i < w; i++) begin
      if (l == chgLine && i == chgPix) reqMode = chgVal;
      if (l == chg2Line && i == chgPix) reqMode = chg2Val;
      p = stubConst ? 24'h80FF1C : {8'(fno * 16 + l), 8'(i * 20 + 3), 8'(i ^ (l * 7))};
      applyStimulus(1, 1, 0, 0, p);
      if (greyProbe && l == 1 && i == LAT) checkOutput("grey_active", 64'(pixel_out), 64'hC8C8C8);
      if (blackProbe && i == LAT) checkOutput("black_after_reset", 64'({de_out, pixel_out}), 64'h1000000);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, (i < 2), 0, 24'h0);
      if (greyProbe && l == 1 && i == LAT) checkOutput("grey_blank", 64'(pixel_out), 64'h0);
    end
  endtask

  task automatic applyFrame(input int w, input int h, input int chgLine, input int chgPix,
                            input logic [1:0] chgVal, input int chg2Line, input logic [1:0] chg2Val);
    applyVsync();
    for (int l = 0; l < h; l++) applyLine(w, l, chgLine, chgPix, chgVal, chg2Line, chg2Val);
    fno++;
  endtask

  task automatic plainFrame(input int w, input int h);
    applyFrame(w, h, -1, 0, 2'd0, -1, 2'd0);
  endtask

  // Reference model: output of edge n reflects input record n-LAT; formats change at
  // the rise of the delayed vsync; geometry follows de runs and vsync edges directly.
  bit          synced;
  logic [1:0]  mmode;
  int          run, lastRun, lines, seenEdge, pubd, mh, mv, mst, newStable;
  int          n, j;
  bit          dj, hj, vj, vprev, dn, dpv, vn, vpv;
  logic [23:0] pj, expPix;
  logic [23:0] yy;

  always @(posedge clk) begin
    #1;
    if (started) begin
      n = cyc;
      if (rstA[n]) begin
        synced = 0; mmode = 2'd0; run = 0; lastRun = 0; lines = 0;
        seenEdge = 0; pubd = 0; mh = 0; mv = 0; mst = 0;
        checkOutput("video", 64'({de_out, hsync_out, vsync_out, mode_active, pixel_out}), 64'h0);
        checkOutput("geom", 64'({h_size, v_size, geom_stable}), 64'h0);
      end else begin
        j = n - LAT;
        dj = (j >= 0) ? deA[j] : 1'b0;
        hj = (j >= 0) ? hsA[j] : 1'b0;
        vj = (j >= 0) ? vsA[j] : 1'b0;
        pj = (j >= 0) ? pixA[j] : 24'h0;
        vprev = (j >= 1) ? vsA[j-1] : 1'b0;
        if (vj && !vprev) begin
          synced = 1;
          mmode = modeA[n];
        end
        yy = yccA[n];
        if (!synced || !dj) expPix = 24'h0;
        else case (mmode)
          2'd0:    expPix = pj;
          2'd1:    expPix = yy;
          2'd2:    expPix = {yy[23:16], yy[23:16], yy[23:16]};
          default: expPix = 24'h0;
        endcase
        checkOutput("video", 64'({de_out, hsync_out, vsync_out, mode_active, pixel_out}),
                    64'({dj, hj, vj, (synced ? mmode : 2'd0), expPix}));

        dn  = deA[n];
        dpv = (n >= 1) ? deA[n-1] : 1'b0;
        vn  = vsA[n];
        vpv = (n >= 1) ? vsA[n-1] : 1'b0;
        if (vn && !vpv) begin
          if (seenEdge != 0) begin
            newStable = (pubd != 0 && lastRun == mh && lines == mv) ? 1 : 0;
            mh = lastRun;
            mv = lines;
            mst = newStable;
            pubd = 1;
          end
          seenEdge = 1;
          lines = (dn && !dpv) ? 1 : 0;
        end else if (dn && !dpv && lines < 2047) begin
          lines++;
        end
        if (dn) begin
          if (run < 4095) run++;
        end else if (dpv) begin
          lastRun = run;
          run = 0;
        end
        checkOutput("geom", 64'({h_size, v_size, geom_stable}),
                    64'({HW'(mh), VW'(mv), mst[0]}));
      end
      cyc++;
    end
  end

  initial begin
    rst_n = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
    pixel_in = '0; ycc_in = '0; mode_req = '0;

    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 24'h0);
    checkOutput("reset_outputs", 64'({de_out, pixel_out, mode_active, h_size, v_size, geom_stable}), 64'h0);

    $display("[TB] reset and first frames, YCbCr requested");
    reqMode = 2'd1;
    for (int f = 0; f < 4; f++) plainFrame(8, 4);
    checkOutput("first_mode_active", 64'(mode_active), 64'd1);
    checkOutput("first_h_size", 64'(h_size), 64'd8);
    checkOutput("first_v_size", 64'(v_size), 64'd4);
    checkOutput("first_geom_stable", 64'(geom_stable), 64'd1);

    $display("[TB] grey mode with stubbed converter");
    stubConst = 1; reqMode = 2'd2; greyProbe = 1;
    plainFrame(8, 4);
    plainFrame(8, 4);
    greyProbe = 0; stubConst = 0;
    checkOutput("grey_mode_active", 64'(mode_active), 64'd2);

    $display("[TB] mid-frame request and glitch");
    reqMode = 2'd0;
    plainFrame(8, 4);
    checkOutput("rgb_mode_active", 64'(mode_active), 64'd0);
    applyFrame(8, 4, 1, 4, 2'd1, -1, 2'd0);
    checkOutput("pending_holds_rgb", 64'(mode_active), 64'd0);
    plainFrame(8, 4);
    checkOutput("pending_applied", 64'(mode_active), 64'd1);
    reqMode = 2'd0;
    plainFrame(8, 4);
    applyFrame(8, 4, 1, 4, 2'd1, 2, 2'd0);
    plainFrame(8, 4);
    checkOutput("glitch_ignored", 64'(mode_active), 64'd0);

    $display("[TB] geometry change");
    for (int f = 0; f < 3; f++) plainFrame(8, 4);
    checkOutput("geom_8x4", 64'({h_size, v_size, geom_stable}), 64'({12'd8, 11'd4, 1'b1}));
    plainFrame(6, 4);
    applyVsync();
    checkOutput("geom_6x4", 64'({h_size, v_size, geom_stable}), 64'({12'd6, 11'd4, 1'b0}));

    $display("[TB] pixel counter saturation");
    for (int i = 0; i < 5000; i++) applyStimulus(1, 1, 0, 0, 24'(i));
    idle(4);
    applyVsync();
    checkOutput("sat_h_size", 64'(h_size), 64'd4095);
    checkOutput("sat_v_size", 64'(v_size), 64'd1);

    $display("[TB] reset during active video");
    reqMode = 2'd1;
    applyVsync();
    applyLine(8, 0, -1, 0, 2'd0, -1, 2'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 24'h123456);
    applyStimulus(0, 1, 0, 0, 24'h123456);
    checkOutput("midreset_outputs",
                64'({de_out, hsync_out, vsync_out, pixel_out, mode_active, h_size, v_size, geom_stable}), 64'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 24'h123456);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 24'h654321);
    idle(4);
    blackProbe = 1;
    applyLine(8, 2, -1, 0, 2'd0, -1, 2'd0);
    blackProbe = 0;
    checkOutput("black_mode_active", 64'(mode_active), 64'd0);
    plainFrame(8, 4);
    checkOutput("post_reset_mode", 64'(mode_active), 64'd1);
    checkOutput("post_reset_h_size", 64'(h_size), 64'd0);

    idle(10);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
